// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding and field widths for the parking session timer
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int DEFAULT_RATE_PER_HOUR = 5;

endpackage

// File: rtl/tick_edge_detect.sv
// rtl/tick_edge_detect.sv - one-cycle pulse on each rising edge of a CLK_IN-synchronous timebase level
module tick_edge_detect (
    input  logic CLK_IN,
    input  logic RST,
    input  logic TIMER_CLK,
    output logic TICK
);

    logic tclk_q;

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            tclk_q <= 1'b0;
        end else begin
            tclk_q <= TIMER_CLK;
        end
    end

    // tclk_q clears on reset, so a level already high at release ticks once
    assign TICK = TIMER_CLK & ~tclk_q;

endmodule

// File: rtl/parking_session_timer.sv
// rtl/parking_session_timer.sv - hh:mm:ss session timer with fee on exit; PARKING_GRACE_PERIOD_EN zeroes short-session fees
module parking_session_timer
    import parking_pkg::*;
#(
    parameter int SEC_PER_MIN   = 60,
    parameter int MIN_PER_HOUR  = 60,
    parameter int MAX_HOURS     = 23,
    parameter int RATE_PER_HOUR = DEFAULT_RATE_PER_HOUR,
    parameter int FEE_W         = 8,
    parameter int GRACE_MIN     = 10
) (
    input  logic              CLK_IN,
    input  logic              RST,
    input  logic              TIMER_CLK,
    input  logic              START,
    input  logic              STOP,
    input  logic              ACK,
    output logic              RUNNING,
    output logic [SEC_W-1:0]  SECONDS,
    output logic [MIN_W-1:0]  MINUTES,
    output logic [HOUR_W-1:0] HOURS,
    output logic              OVERFLOW,
    output logic [FEE_W-1:0]  FEE,
    output logic              VALID
);

    localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_PER_MIN - 1);
    localparam logic [MIN_W-1:0]  MIN_LAST   = MIN_W'(MIN_PER_HOUR - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(MAX_HOURS);
    localparam logic [MIN_W-1:0]  GRACE_LAST = MIN_W'(GRACE_MIN);
    localparam logic [31:0]       FEE_MAX    = (32'd1 << FEE_W) - 32'd1;
`ifdef PARKING_GRACE_PERIOD_EN
    localparam bit GRACE_ON = 1'b1;
`else
    localparam bit GRACE_ON = 1'b0;
`endif

    state_t             state_q, state_d;
    logic               tick;
    logic [SEC_W-1:0]   sec_q;
    logic [MIN_W-1:0]   min_q;
    logic [HOUR_W-1:0]  hour_q;
    logic               ovf_q;
    logic [FEE_W-1:0]   fee_q;
    logic [FEE_W-1:0]   fee_calc;
    logic [HOUR_W:0]    billable;
    logic [31:0]        product;
    logic               part_hour;
    logic               grace_free;
    logic               at_max;

    tick_edge_detect u_tick (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .TIMER_CLK (TIMER_CLK),
        .TICK      (tick)
    );

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP has priority over START because START is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN:  if (STOP)  state_d = ST_DONE;
            ST_DONE: if (ACK)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign at_max = (hour_q == HOUR_LAST) && (min_q == MIN_LAST) && (sec_q == SEC_LAST);

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            ovf_q  <= 1'b0;
            fee_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        sec_q  <= '0;
                        min_q  <= '0;
                        hour_q <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (STOP) begin
                        fee_q <= fee_calc;
                    end else if (tick) begin
                        if (at_max) begin
                            ovf_q <= 1'b1;
                        end else if (sec_q == SEC_LAST) begin
                            sec_q <= '0;
                            if (min_q == MIN_LAST) begin
                                min_q  <= '0;
                                hour_q <= hour_q + 1'b1;
                            end else begin
                                min_q <= min_q + 1'b1;
                            end
                        end else begin
                            sec_q <= sec_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Any started hour bills in full; an empty session still bills one hour
    always_comb begin
        part_hour  = (min_q != '0) || (sec_q != '0);
        billable   = {1'b0, hour_q} + {{HOUR_W{1'b0}}, part_hour};
        if (billable == '0) begin
            billable = {{HOUR_W{1'b0}}, 1'b1};
        end
        product    = 32'(billable) * 32'(RATE_PER_HOUR);
        fee_calc   = (product > FEE_MAX) ? '1 : product[FEE_W-1:0];
        grace_free = (hour_q == '0) &&
                     ((min_q < GRACE_LAST) || ((min_q == GRACE_LAST) && (sec_q == '0)));
        if (GRACE_ON && grace_free) begin
            fee_calc = '0;
        end
    end

    assign RUNNING  = (state_q == ST_RUN);
    assign VALID    = (state_q == ST_DONE);
    assign SECONDS  = sec_q;
    assign MINUTES  = min_q;
    assign HOURS    = hour_q;
    assign OVERFLOW = ovf_q;
    assign FEE      = fee_q;

endmodule

// File: tb/tb_parking_session_timer.sv
// tb/tb_parking_session_timer.sv - directed table and corner sequences for parking_session_timer
module tb_parking_session_timer;

`ifdef PARKING_GRACE_PERIOD_EN
    localparam int GF = 0;
`else
    localparam int GF = 5;
`endif

    logic       CLK_IN = 1'b0;
    logic       RST = 1'b1;
    logic       TIMER_CLK = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       ACK = 1'b0;

    logic       running, ovf, valid;
    logic [5:0] seconds, minutes;
    logic [4:0] hours;
    logic [7:0] fee;

    logic       running2, ovf2, valid2;
    logic [5:0] seconds2, minutes2;
    logic [4:0] hours2;
    logic [7:0] fee2;

    int total = 0;
    int bad = 0;

    typedef struct {
        int edges;
        int exp_sec;
        int exp_min;
        int exp_hr;
        int exp_fee;
    } vec_t;

    vec_t vecs[7];

    always #5 CLK_IN = ~CLK_IN;

    parking_session_timer dut (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .TIMER_CLK (TIMER_CLK),
        .START     (START),
        .STOP      (STOP),
        .ACK       (ACK),
        .RUNNING   (running),
        .SECONDS   (seconds),
        .MINUTES   (minutes),
        .HOURS     (hours),
        .OVERFLOW  (ovf),
        .FEE       (fee),
        .VALID     (valid)
    );

    // Short minutes/hours keep the saturation run within a few hundred cycles
    parking_session_timer #(
        .SEC_PER_MIN   (2),
        .MIN_PER_HOUR  (2),
        .MAX_HOURS     (23),
        .RATE_PER_HOUR (20),
        .FEE_W         (8)
    ) dut_sat (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .TIMER_CLK (TIMER_CLK),
        .START     (START),
        .STOP      (STOP),
        .ACK       (ACK),
        .RUNNING   (running2),
        .SECONDS   (seconds2),
        .MINUTES   (minutes2),
        .HOURS     (hours2),
        .OVERFLOW  (ovf2),
        .FEE       (fee2),
        .VALID     (valid2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
    endtask

    task automatic pulse_ack();
        ACK = 1'b1;
        step();
        ACK = 1'b0;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            TIMER_CLK = 1'b1;
            step();
            TIMER_CLK = 1'b0;
            step();
        end
    endtask

    initial begin
        vecs[0] = '{75,   15, 1,  0, GF};
        vecs[1] = '{0,    0,  0,  0, GF};
        vecs[2] = '{7200, 0,  0,  2, 10};
        vecs[3] = '{7201, 1,  0,  2, 15};
        vecs[4] = '{599,  59, 9,  0, GF};
        vecs[5] = '{600,  0,  10, 0, GF};
        vecs[6] = '{601,  1,  10, 0, 5};

        repeat (3) step();
        check("reset_running", running, 0);
        check("reset_valid", valid, 0);
        check("reset_seconds", seconds, 0);
        check("reset_fee", fee, 0);
        check("reset_overflow", ovf, 0);
        RST = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            pulse_start();
            check($sformatf("v%0d_running", v), running, 1);
            edges(vecs[v].edges);
            check($sformatf("v%0d_valid_before_stop", v), valid, 0);
            pulse_stop();
            check($sformatf("v%0d_valid", v), valid, 1);
            check($sformatf("v%0d_running_done", v), running, 0);
            check($sformatf("v%0d_seconds", v), seconds, vecs[v].exp_sec);
            check($sformatf("v%0d_minutes", v), minutes, vecs[v].exp_min);
            check($sformatf("v%0d_hours", v), hours, vecs[v].exp_hr);
            check($sformatf("v%0d_fee", v), fee, vecs[v].exp_fee);
            pulse_ack();
            check($sformatf("v%0d_valid_after_ack", v), valid, 0);
            check($sformatf("v%0d_fee_hold", v), fee, vecs[v].exp_fee);
        end

        // START and STOP together while running: STOP wins
        pulse_start();
        edges(5);
        START = 1'b1;
        STOP = 1'b1;
        step();
        START = 1'b0;
        STOP = 1'b0;
        check("startstop_valid", valid, 1);
        check("startstop_seconds", seconds, 5);
        pulse_start();
        check("start_in_done_valid", valid, 1);
        check("start_in_done_running", running, 0);
        pulse_ack();
        check("ack_valid", valid, 0);
        check("ack_running", running, 0);

        // STOP coinciding with a tick drops the tick; ticks in DONE are ignored
        pulse_start();
        edges(3);
        TIMER_CLK = 1'b1;
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        TIMER_CLK = 1'b0;
        step();
        check("stop_tick_seconds", seconds, 3);
        check("stop_tick_fee", fee, GF);
        edges(2);
        check("done_tick_seconds", seconds, 3);
        pulse_ack();

        // Reset mid-session discards everything
        pulse_start();
        edges(30);
        check("pre_reset_seconds", seconds, 30);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_running", running, 0);
        check("rst_seconds", seconds, 0);
        check("rst_fee", fee, 0);
        check("rst_valid", valid, 0);
        pulse_stop();
        check("rst_stop_valid", valid, 0);

        // Saturation: 23:1:1 is the last count with 2 s/min and 2 min/h
        pulse_start();
        edges(95);
        check("sat_hours_at_max", hours2, 23);
        check("sat_overflow_at_max", ovf2, 0);
        edges(3);
        check("sat_overflow", ovf2, 1);
        check("sat_hours_hold", hours2, 23);
        check("sat_minutes_hold", minutes2, 1);
        check("sat_seconds_hold", seconds2, 1);
        pulse_stop();
        check("sat_valid", valid2, 1);
        check("sat_fee", fee2, 255);
        pulse_ack();
        pulse_start();
        check("sat_restart_overflow", ovf2, 0);
        check("sat_restart_hours", hours2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
